vc_test_sink: RTL and testbench
===============================

# vc_test_sink

Latency-insensitive val/rdy message consumer for unit-test harnesses; the receiving counterpart of the test source. It holds a memory of expected messages, accepts one message per handshake, compares each against the expected entry in order, and reports completion, a sticky error flag, an error count and the index of the first mismatch. The bench connects it to the output port of the design under test.

## Interface
- `p_msg_nbits`, 1: message width in bits.
- `p_num_msgs`, 1024: depth of expected-message memory; also the number of messages consumed before `done`.
- `p_max_delay`, 0: maximum random stall cycles after each transfer (used only with random backpressure compiled in).
- `p_lfsr_seed`, 16'hACE1: nonzero LFSR reset value.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset asserted).
- `val`  in  1  message valid from DUT.
- `rdy`  out  1  sink ready.
- `msg`  in  p_msg_nbits  received message.
- `done`  out  1  high once all `p_num_msgs` messages have been accepted.
- `err`  out  1  sticky; high after any mismatch.
- `num_errs`  out  16  mismatch count, saturating at 16'hFFFF.
- `err_idx`  out  $clog2(p_num_msgs)  index of first mismatching message.

Expected data lives in `m[p_num_msgs-1:0]`, loaded by the bench hierarchically before reset deasserts.

## Operation
- States: `HOLD`, `RECV`, `DONE`.
- `HOLD`: entered while `reset`=0 and for exactly one cycle after `reset` rises (registered reset). `rdy`=0. Next: `RECV`.
- `RECV`: `rdy`=1 (subject to stall counter when configured). Transfer (`go`) = `val && rdy`.
- On `go`: compare `msg !== m[index]` (4-state; X/Z in `msg` counts as mismatch). On mismatch: `num_errs` += 1 (saturating); if `err`=0 then `err_idx` <= `index`; `err` <= 1. Index increments.
- On `go` with `index == p_num_msgs-1`: next state `DONE`; index not incremented (no wrap).
- `DONE`: `rdy`=0, `done`=1; `val` ignored. Leaves only via reset.
- Reset (`reset`=0) in any state, including mid-stream: state `HOLD`, index 0, `done`=0, `err`=0, `num_errs`=0, `err_idx`=0, stall counter 0, LFSR = `p_lfsr_seed`. Expected memory not cleared.
- Assertion: outside reset, `val` must not be X; violation reported via the codebase assertion macro.

## Timing
- `rdy` is a function of registered state only; never depends combinationally on `val` or `msg`.
- Compare and counter updates take effect the cycle after the accepting edge; `err`/`num_errs` are valid one cycle after the offending transfer.
- Throughput without stalls: one message per cycle; `done` rises the cycle after the last transfer.
- Reset values: `rdy`=0, `done`=0, `err`=0, `num_errs`=0, `err_idx`=0.
- Minimum reset-to-first-accept: first rising edge with `reset`=1 moves to HOLD-exit; `rdy`=1 on the following cycle.

## Configuration
- `VC_TEST_SINK_RAND_DELAY_EN` defined: 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle outside reset; on each `go` the stall counter loads `lfsr % (p_max_delay+1)`; while counter ≠ 0, `rdy`=0 and counter decrements each cycle. `p_max_delay`=0 gives full throughput.
- Not defined: no LFSR or counter; `rdy`=1 in every `RECV` cycle; `p_max_delay`/`p_lfsr_seed` ignored.

## Structure
- Package `vc_test_sink_pkg`: state enum (`HOLD`, `RECV`, `DONE`), `NUM_ERRS_NBITS`=16, LFSR tap constant.
- Sub-module `vc_lfsr16` (seed parameter, enable, 16-bit state out), instantiated only under the macro.
- Index register reuses the existing enable/reset register component.

## Test plan
- 4 expected msgs {8'h01,8'h02,8'h03,8'h04}, DUT sends same with `val` held 1 -> accepted on 4 consecutive cycles, `done`=1 cycle after, `err`=0, `num_errs`=0.
- Same memory, DUT sends {01,FF,03,EE} -> `err`=1 after 2nd transfer, `err_idx`=1, final `num_errs`=2, `done`=1.
- `val` toggled 1,0,1,0… -> only cycles with `val`=1 consume; index advances exactly 4 times; extra `val` after `done` ignored (`rdy`=0).
- Reset pulled low after 2 of 4 messages, one with mismatch -> all outputs return to 0, `rdy`=0 for reset plus one cycle; full resend passes cleanly.
- With `VC_TEST_SINK_RAND_DELAY_EN`, `p_max_delay`=3, 64 messages -> every inter-transfer gap ≤3 stall cycles, at least one nonzero gap, all 64 matched, `done`=1.
- Force 70000 mismatching transfers (`p_num_msgs`=131072) -> `num_errs` saturates at 16'hFFFF, `err_idx`=0.

Source files
------------

// File: rtl/vc_test_sink_pkg.sv
// Shared types and constants for the val/rdy test sink and its LFSR.
// The optional random-backpressure feature is selected by VC_TEST_SINK_RAND_DELAY_EN.
package vc_test_sink_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NUM_ERRS_NBITS = 16;

  // Taps 16,14,13,11 of a Fibonacci LFSR map onto state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/vc_lfsr16.sv
// 16-bit Fibonacci LFSR used to pick random stall lengths in the test sink.
// Only instantiated when VC_TEST_SINK_RAND_DELAY_EN is defined.
module vc_lfsr16
  import vc_test_sink_pkg::*;
#(
  parameter logic [15:0] p_seed = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  output logic [15:0] state_o
);

  logic [15:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d = {state_q[14:0], ^(state_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= p_seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/vc_test_sink.sv
// Val/rdy message sink: compares each accepted message against m[] in order.
// Define VC_TEST_SINK_RAND_DELAY_EN to add LFSR-driven random stalls after each transfer.
module vc_test_sink
  import vc_test_sink_pkg::*;
#(
  parameter int          p_msg_nbits = 1,
  parameter int          p_num_msgs  = 1024,
  parameter int          p_max_delay = 0,
  parameter logic [15:0] p_lfsr_seed = 16'hACE1,
  localparam int         IDX_W       = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      val,
  output logic                      rdy,
  input  logic [p_msg_nbits-1:0]    msg,
  output logic                      done,
  output logic                      err,
  output logic [NUM_ERRS_NBITS-1:0] num_errs,
  output logic [IDX_W-1:0]          err_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(p_num_msgs - 1);

  // Expected messages, written hierarchically by the harness before reset deasserts.
  logic [p_msg_nbits-1:0] m [p_num_msgs];

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      err_q, err_d;
  logic [NUM_ERRS_NBITS-1:0] num_errs_q, num_errs_d;
  logic [IDX_W-1:0]          err_idx_q, err_idx_d;
  logic                      stall_free;
  logic                      go;
  logic                      mismatch;

`ifdef VC_TEST_SINK_RAND_DELAY_EN
  localparam logic [15:0] DELAY_MOD = 16'(p_max_delay + 1);

  logic [15:0] lfsr;
  logic [15:0] stall_q, stall_d;

  vc_lfsr16 #(.p_seed(p_lfsr_seed)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  always_comb begin
    stall_d = stall_q;
    if (go) begin
      stall_d = lfsr % DELAY_MOD;
    end else if (stall_q != 16'd0) begin
      stall_d = stall_q - 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_free = (stall_q == 16'd0);
`else
  assign stall_free = 1'b1;
`endif

  // rdy comes from registered state only, so it never depends on val or msg.
  assign rdy      = (state_q == RECV) && stall_free;
  assign go       = val && rdy;
  assign mismatch = (msg !== m[idx_q]);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    num_errs_d = num_errs_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      HOLD: state_d = RECV;
      RECV: begin
        if (go) begin
          if (mismatch) begin
            if (num_errs_q != '1) begin
              num_errs_d = num_errs_q + 1'b1;
            end
            if (!err_q) begin
              err_idx_d = idx_q;
            end
            err_d = 1'b1;
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= HOLD;
      idx_q      <= '0;
      err_q      <= 1'b0;
      num_errs_q <= '0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      num_errs_q <= num_errs_d;
      err_idx_q  <= err_idx_d;
    end
  end

  // An unknown val outside reset means the upstream DUT is broken.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!$isunknown(val));
    end
  end

  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign num_errs = num_errs_q;
  assign err_idx  = err_idx_q;

endmodule

// File: tb/tb_vc_test_sink.sv
// Self-checking bench for vc_test_sink: directed cases, randomized rounds against a
// reference model, counter saturation, and (with VC_TEST_SINK_RAND_DELAY_EN) random stalls.
module tb_vc_test_sink;

  logic        clk = 1'b0;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  logic        reset, val;
  logic [7:0]  msg;
  logic        rdy, done, err;
  logic [15:0] numErrs;
  logic [1:0]  errIdx;

  logic        sReset, sVal;
  logic [0:0]  sMsg;
  logic        sRdy, sDone, sErr;
  logic [15:0] sNumErrs;
  logic [16:0] sErrIdx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vc_test_sink #(.p_msg_nbits(8), .p_num_msgs(4)) dut (
    .clk(clk), .reset(reset), .val(val), .rdy(rdy), .msg(msg),
    .done(done), .err(err), .num_errs(numErrs), .err_idx(errIdx)
  );

  vc_test_sink #(.p_msg_nbits(1), .p_num_msgs(131072)) sdut (
    .clk(clk), .reset(sReset), .val(sVal), .rdy(sRdy), .msg(sMsg),
    .done(sDone), .err(sErr), .num_errs(sNumErrs), .err_idx(sErrIdx)
  );

`ifdef VC_TEST_SINK_RAND_DELAY_EN
  logic        dReset, dVal;
  logic [7:0]  dMsg;
  logic        dRdy, dDone, dErr;
  logic [15:0] dNumErrs;
  logic [5:0]  dErrIdx;

  vc_test_sink #(.p_msg_nbits(8), .p_num_msgs(64), .p_max_delay(3)) ddut (
    .clk(clk), .reset(dReset), .val(dVal), .rdy(dRdy), .msg(dMsg),
    .done(dDone), .err(dErr), .num_errs(dNumErrs), .err_idx(dErrIdx)
  );
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic loadMain(input logic [7:0] v [4]);
    for (int i = 0; i < 4; i++) dut.m[i] = v[i];
  endtask

  // Called at a negedge; leaves the main DUT in RECV at a negedge.
  task automatic applyReset();
    reset = 1'b0;
    val   = 1'b0;
    @(negedge clk);
    checkOutput("rst_rdy", rdy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_numerrs", numErrs, 16'h0);
    checkOutput("rst_erridx", errIdx, 2'd0);
    reset = 1'b1;
    #1;
    checkOutput("hold_rdy", rdy, 1'b0);
    @(negedge clk);
    checkOutput("recv_rdy", rdy, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge, val left high.
  task automatic applyStimulus(input logic [7:0] d, output int acceptCyc);
    int w = 0;
    msg = d;
    val = 1'b1;
    while (!rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!rdy) checkOutput("xfer_timeout", w, 0);
    @(negedge clk);
    acceptCyc = cyc;
  endtask

  initial begin
    logic [7:0] expv [4];
    logic [7:0] sent;
    int         ac [4];
    int         dummy;
    int         mCount, mFirst;
    logic       mErr;

    reset = 1'b0; val = 1'b0; msg = 8'h00;
    sReset = 1'b0; sVal = 1'b0; sMsg = 1'b0;
`ifdef VC_TEST_SINK_RAND_DELAY_EN
    dReset = 1'b0; dVal = 1'b0; dMsg = 8'h00;
`endif
    repeat (3) @(negedge clk);

    // Clean stream, val held high: four back-to-back transfers.
    expv = '{8'h01, 8'h02, 8'h03, 8'h04};
    loadMain(expv);
    applyReset();
    for (int k = 0; k < 4; k++) applyStimulus(expv[k], ac[k]);
    val = 1'b0;
    checkOutput("t1_consecutive", ac[3] - ac[0], 3);
    checkOutput("t1_done", done, 1'b1);
    checkOutput("t1_err", err, 1'b0);
    checkOutput("t1_numerrs", numErrs, 16'h0);
    checkOutput("t1_rdy_done", rdy, 1'b0);

    // Two mismatches; first one at index 1.
    applyReset();
    applyStimulus(8'h01, dummy);
    checkOutput("t2_err_after1", err, 1'b0);
    applyStimulus(8'hFF, dummy);
    checkOutput("t2_err_after2", err, 1'b1);
    checkOutput("t2_erridx_after2", errIdx, 2'd1);
    checkOutput("t2_done_mid", done, 1'b0);
    applyStimulus(8'h03, dummy);
    applyStimulus(8'hEE, dummy);
    val = 1'b0;
    checkOutput("t2_numerrs", numErrs, 16'd2);
    checkOutput("t2_erridx", errIdx, 2'd1);
    checkOutput("t2_done", done, 1'b1);

    // val toggling; extra val after done is ignored.
    applyReset();
    for (int k = 0; k < 4; k++) begin
      val = 1'b0;
      @(negedge clk);
      checkOutput("t3_done_early", done, 1'b0);
      applyStimulus(expv[k], dummy);
    end
    checkOutput("t3_done", done, 1'b1);
    msg = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("t3_rdy_after_done", rdy, 1'b0);
    end
    val = 1'b0;
    checkOutput("t3_numerrs", numErrs, 16'h0);
    checkOutput("t3_err", err, 1'b0);

    // Reset mid-stream after a mismatch, then a clean resend.
    applyReset();
    applyStimulus(8'h01, dummy);
    applyStimulus(8'hAA, dummy);
    val = 1'b0;
    checkOutput("t4_err_pre", err, 1'b1);
    applyReset();
    for (int k = 0; k < 4; k++) applyStimulus(expv[k], dummy);
    val = 1'b0;
    checkOutput("t4_done", done, 1'b1);
    checkOutput("t4_err", err, 1'b0);
    checkOutput("t4_numerrs", numErrs, 16'h0);

    // Randomized rounds against a count/first-index model.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) expv[i] = 8'($urandom);
      loadMain(expv);
      applyReset();
      mCount = 0; mFirst = 0; mErr = 1'b0;
      for (int k = 0; k < 4; k++) begin
        val = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        sent = expv[k];
        if ($urandom_range(0, 2) == 0) sent = expv[k] ^ 8'($urandom_range(1, 255));
        if (sent != expv[k]) begin
          if (!mErr) mFirst = k;
          mErr = 1'b1;
          mCount++;
        end
        applyStimulus(sent, dummy);
      end
      val = 1'b0;
      checkOutput("rnd_done", done, 1'b1);
      checkOutput("rnd_err", err, mErr);
      checkOutput("rnd_numerrs", numErrs, mCount);
      checkOutput("rnd_erridx", errIdx, mFirst);
    end

    // Saturation: 70000 mismatching transfers into an all-zero memory.
    for (int i = 0; i < 131072; i++) sdut.m[i] = 1'b0;
    sReset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    begin
      int acc = 0;
      int g = 0;
      sVal = 1'b1;
      sMsg = 1'b1;
      while (acc < 70000 && g < 80000) begin
        if (sRdy) acc++;
        @(negedge clk);
        g++;
      end
      sVal = 1'b0;
      checkOutput("sat_transfers", acc, 70000);
    end
    @(negedge clk);
    checkOutput("sat_numerrs", sNumErrs, 16'hFFFF);
    checkOutput("sat_erridx", sErrIdx, 17'd0);
    checkOutput("sat_err", sErr, 1'b1);
    checkOutput("sat_done", sDone, 1'b0);

`ifdef VC_TEST_SINK_RAND_DELAY_EN
    // Random stalls: gaps bounded by p_max_delay and at least one nonzero.
    begin
      logic [7:0] dv [64];
      int maxGap = 0;
      int nonzero = 0;
      for (int i = 0; i < 64; i++) begin
        dv[i] = 8'($urandom);
        ddut.m[i] = dv[i];
      end
      dReset = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 64; k++) begin
        int w = 0;
        dMsg = dv[k];
        dVal = 1'b1;
        while (!dRdy && w < 20) begin
          @(negedge clk);
          w++;
        end
        if (w > maxGap) maxGap = w;
        if (w != 0) nonzero++;
        @(negedge clk);
      end
      dVal = 1'b0;
      checkOutput("dly_maxgap_ok", maxGap <= 3, 1'b1);
      checkOutput("dly_some_stall", nonzero > 0, 1'b1);
      checkOutput("dly_done", dDone, 1'b1);
      checkOutput("dly_numerrs", dNumErrs, 16'h0);
      checkOutput("dly_err", dErr, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
